// File: rtl/io_stim_sequencer.sv
// On-board stimulus player: replays a table of switch words onto io_rdata and
// checks io_wdata against a masked expected value at the end of every step.
module io_stim_sequencer #(
    parameter int DATA_W = 24,
    parameter int OUT_W  = 24,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5,
    parameter int HOLD_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_stim,
    input  logic [OUT_W-1:0]  load_exp,
    input  logic [OUT_W-1:0]  load_mask,
    input  logic              start,
    input  logic              abort,
    input  logic              loop_mode,
    input  logic [HOLD_W-1:0] hold_cycles,
    input  logic [ADDR_W:0]   num_steps,
    input  logic [OUT_W-1:0]  io_wdata,
    output logic [DATA_W-1:0] io_rdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] step_idx,
    output logic              mismatch,
    output logic [CNT_W-1:0]  mismatch_count,
    output logic              first_fail_valid,
    output logic [ADDR_W-1:0] first_fail_idx
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_HOLD,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] stim_mem [DEPTH];
    logic [OUT_W-1:0]  exp_mem  [DEPTH];
    logic [OUT_W-1:0]  mask_mem [DEPTH];

    state_t            state_reg;
    logic [DATA_W-1:0] io_rdata_reg;
    logic [OUT_W-1:0]  exp_reg;
    logic [OUT_W-1:0]  mask_reg;
    logic [HOLD_W-1:0] hold_eff_reg;
    logic [HOLD_W-1:0] hold_cnt_reg;
    logic [ADDR_W:0]   n_reg;
    logic [ADDR_W-1:0] step_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              mismatch_reg;
    logic [CNT_W-1:0]  count_reg;
    logic              ffv_reg;
    logic [ADDR_W-1:0] ffi_reg;

    logic fail;
    logic last_step;

    assign fail      = |((io_wdata ^ exp_reg) & mask_reg);
    assign last_step = ({1'b0, step_reg} == (n_reg - 1'b1));

    // Table writes are gated by busy so the entry under check cannot change mid-step.
    always_ff @(posedge clk) begin
        if (load_we && !busy_reg && ({1'b0, load_addr} < DEPTH_L)) begin
            stim_mem[load_addr] <= load_stim;
            exp_mem[load_addr]  <= load_exp;
            mask_mem[load_addr] <= load_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            io_rdata_reg <= '0;
            exp_reg      <= '0;
            mask_reg     <= '0;
            hold_eff_reg <= '0;
            hold_cnt_reg <= '0;
            n_reg        <= '0;
            step_reg     <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            mismatch_reg <= 1'b0;
            count_reg    <= '0;
            ffv_reg      <= 1'b0;
            ffi_reg      <= '0;
        end else begin
            done_reg     <= 1'b0;
            mismatch_reg <= 1'b0;
            if (abort) begin
                state_reg    <= S_IDLE;
                io_rdata_reg <= '0;
                busy_reg     <= 1'b0;
            end else begin
                case (state_reg)
                    S_IDLE: begin
                        if (start && (num_steps != '0)) begin
                            hold_eff_reg <= (hold_cycles == '0) ? HOLD_W'(1) : hold_cycles;
                            n_reg        <= (num_steps > DEPTH_L) ? DEPTH_L : num_steps;
                            step_reg     <= '0;
                            count_reg    <= '0;
                            ffv_reg      <= 1'b0;
                            ffi_reg      <= '0;
                            busy_reg     <= 1'b1;
                            state_reg    <= S_APPLY;
                        end
                    end
                    S_APPLY: begin
                        // Expected/mask are captured alongside the stimulus so CHECK uses registered reads.
                        io_rdata_reg <= stim_mem[step_reg];
                        exp_reg      <= exp_mem[step_reg];
                        mask_reg     <= mask_mem[step_reg];
                        hold_cnt_reg <= hold_eff_reg;
                        state_reg    <= S_HOLD;
                    end
                    S_HOLD: begin
                        if (hold_cnt_reg == HOLD_W'(1)) begin
                            state_reg <= S_CHECK;
                        end else begin
                            hold_cnt_reg <= hold_cnt_reg - 1'b1;
                        end
                    end
                    S_CHECK: begin
                        if (fail) begin
                            mismatch_reg <= 1'b1;
                            if (count_reg != '1) begin
                                count_reg <= count_reg + 1'b1;
                            end
                            if (!ffv_reg) begin
                                ffv_reg <= 1'b1;
                                ffi_reg <= step_reg;
                            end
                        end
                        if (!last_step) begin
                            step_reg  <= step_reg + 1'b1;
                            state_reg <= S_APPLY;
                        end else if (loop_mode) begin
                            step_reg  <= '0;
                            state_reg <= S_APPLY;
                        end else begin
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                            state_reg <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        state_reg <= S_IDLE;
                    end
                    default: begin
                        state_reg <= S_IDLE;
                        busy_reg  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign io_rdata         = io_rdata_reg;
    assign busy             = busy_reg;
    assign done             = done_reg;
    assign step_idx         = step_reg;
    assign mismatch         = mismatch_reg;
    assign mismatch_count   = count_reg;
    assign first_fail_valid = ffv_reg;
    assign first_fail_idx   = ffi_reg;

endmodule

// File: tb/tb_io_stim_sequencer.sv
// Scoreboard bench for io_stim_sequencer: per-step expectations are queued when a
// run is set up and compared as each CHECK completes.
module tb_io_stim_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_we;
    logic [4:0]  load_addr;
    logic [23:0] load_stim;
    logic [23:0] load_exp;
    logic [23:0] load_mask;
    logic        start;
    logic        abort;
    logic        loop_mode;
    logic [15:0] hold_cycles;
    logic [5:0]  num_steps;
    logic [23:0] io_wdata;
    logic [23:0] io_rdata;
    logic        busy;
    logic        done;
    logic [4:0]  step_idx;
    logic        mismatch;
    logic [1:0]  mismatch_count;
    logic        first_fail_valid;
    logic [4:0]  first_fail_idx;

    io_stim_sequencer #(
        .DATA_W(24), .OUT_W(24), .DEPTH(32), .ADDR_W(5), .HOLD_W(16), .CNT_W(2)
    ) dut (
        .clk(clk), .rst(rst),
        .load_we(load_we), .load_addr(load_addr), .load_stim(load_stim),
        .load_exp(load_exp), .load_mask(load_mask),
        .start(start), .abort(abort), .loop_mode(loop_mode),
        .hold_cycles(hold_cycles), .num_steps(num_steps),
        .io_wdata(io_wdata), .io_rdata(io_rdata),
        .busy(busy), .done(done), .step_idx(step_idx),
        .mismatch(mismatch), .mismatch_count(mismatch_count),
        .first_fail_valid(first_fail_valid), .first_fail_idx(first_fail_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  idx;
        logic [23:0] rdata;
        logic [23:0] wdata;
        logic        fail;
        logic        loop;
        logic        last;
    } step_t;

    step_t       exp_q[$];
    int          checks = 0;
    int          failures = 0;
    int          model_cnt;
    logic        model_ffv;
    logic [4:0]  model_ffi;
    int          cyc;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    function automatic void push_step(input logic [4:0] idx, input logic [23:0] stim,
                                      input logic [23:0] exp_v, input logic [23:0] mask_v,
                                      input logic [23:0] wdata, input logic loop, input logic last);
        step_t r;
        r.idx   = idx;
        r.rdata = stim;
        r.wdata = wdata;
        r.fail  = |((wdata ^ exp_v) & mask_v);
        r.loop  = loop;
        r.last  = last;
        exp_q.push_back(r);
    endfunction

    task automatic load_entry(input int addr, input logic [23:0] stim,
                              input logic [23:0] exp_v, input logic [23:0] mask_v);
        load_addr = 5'(addr);
        load_stim = stim;
        load_exp  = exp_v;
        load_mask = mask_v;
        load_we   = 1'b1;
        @(posedge clk); #1;
        load_we   = 1'b0;
    endtask

    // Starts a run and consumes every queued step; exp_cycles > 0 also checks done timing.
    task automatic run(input int hold, input int nreq, input int exp_cycles);
        int    hold_eff;
        step_t r;
        hold_eff    = (hold == 0) ? 1 : hold;
        hold_cycles = 16'(hold);
        num_steps   = 6'(nreq);
        start       = 1'b1;
        @(posedge clk); #1;
        start       = 1'b0;
        cyc         = 1;
        model_cnt   = 0;
        model_ffv   = 1'b0;
        model_ffi   = '0;
        while (exp_q.size() > 0) begin
            r = exp_q.pop_front();
            repeat (hold_eff + 1) @(posedge clk);
            #1;
            cyc += hold_eff + 1;
            check_val("rdata", 32'(io_rdata), 32'(r.rdata));
            check_val("step_idx", 32'(step_idx), 32'(r.idx));
            check_val("busy_run", 32'(busy), 32'd1);
            io_wdata  = r.wdata;
            loop_mode = r.loop;
            @(posedge clk); #1;
            cyc++;
            io_wdata = '0;
            if (r.fail) begin
                if (model_cnt != 3) model_cnt++;
                if (!model_ffv) begin
                    model_ffv = 1'b1;
                    model_ffi = r.idx;
                end
            end
            check_val("mismatch", 32'(mismatch), 32'(r.fail));
            check_val("count", 32'(mismatch_count), 32'(model_cnt));
            check_val("done", 32'(done), 32'(r.last));
            check_val("ffv", 32'(first_fail_valid), 32'(model_ffv));
            check_val("ffi", 32'(first_fail_idx), 32'(model_ffi));
            $display("step idx=%0d rdata=%h wdata=%h mismatch=%0b count=%0d done=%0b",
                     r.idx, io_rdata, r.wdata, mismatch, mismatch_count, done);
            if (r.last) begin
                check_val("busy_done", 32'(busy), 32'd0);
                if (exp_cycles > 0) check_val("done_cycle", 32'(cyc), 32'(exp_cycles));
                @(posedge clk); #1;
                check_val("done_pulse_end", 32'(done), 32'd0);
            end
        end
    endtask

    initial begin
        rst = 1'b1; load_we = 1'b0; load_addr = '0; load_stim = '0; load_exp = '0;
        load_mask = '0; start = 1'b0; abort = 1'b0; loop_mode = 1'b0;
        hold_cycles = '0; num_steps = '0; io_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_rdata", 32'(io_rdata), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_count", 32'(mismatch_count), 32'd0);
        check_val("rst_ffv", 32'(first_fail_valid), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Clean loopback run: done 19 cycles after the start cycle.
        load_entry(0, 24'h0A0078, 24'h0A0078, 24'hFFFFFF);
        load_entry(1, 24'hEF0000, 24'hEF0000, 24'hFFFFFF);
        load_entry(2, 24'h010008, 24'h010008, 24'hFFFFFF);
        push_step(0, 24'h0A0078, 24'h0A0078, 24'hFFFFFF, 24'h0A0078, 1'b0, 1'b0);
        push_step(1, 24'hEF0000, 24'hEF0000, 24'hFFFFFF, 24'hEF0000, 1'b0, 1'b0);
        push_step(2, 24'h010008, 24'h010008, 24'hFFFFFF, 24'h010008, 1'b0, 1'b1);
        run(4, 3, 19);

        // Step 1 output forced to zero.
        push_step(0, 24'h0A0078, 24'h0A0078, 24'hFFFFFF, 24'h0A0078, 1'b0, 1'b0);
        push_step(1, 24'hEF0000, 24'hEF0000, 24'hFFFFFF, 24'h000000, 1'b0, 1'b0);
        push_step(2, 24'h010008, 24'h010008, 24'hFFFFFF, 24'h010008, 1'b0, 1'b1);
        run(4, 3, 19);

        // Masking: low byte only passes, full mask fails.
        load_entry(0, 24'h123456, 24'h000012, 24'h0000FF);
        load_entry(1, 24'h654321, 24'h000012, 24'hFFFFFF);
        push_step(0, 24'h123456, 24'h000012, 24'h0000FF, 24'hABCD12, 1'b0, 1'b0);
        push_step(1, 24'h654321, 24'h000012, 24'hFFFFFF, 24'hABCD12, 1'b0, 1'b1);
        run(1, 2, 0);

        // Looping with every step failing; count saturates at 3, loop dropped on final pass.
        load_entry(0, 24'h111111, 24'h000000, 24'hFFFFFF);
        load_entry(1, 24'h222222, 24'h000000, 24'hFFFFFF);
        for (int p = 0; p < 3; p++) begin
            push_step(0, 24'h111111, 24'h0, 24'hFFFFFF, 24'hFFFFFF, 1'b1, 1'b0);
            push_step(1, 24'h222222, 24'h0, 24'hFFFFFF, 24'hFFFFFF, (p != 2), (p == 2));
        end
        loop_mode = 1'b1;
        run(2, 2, 0);
        loop_mode = 1'b0;

        // Full table, hold 0 -> 3-cycle steps, num_steps clamped to 32.
        for (int i = 0; i < 32; i++) begin
            load_entry(i, 24'(i * 'h010101), 24'(i * 'h010101), 24'hFFFFFF);
        end
        for (int i = 0; i < 32; i++) begin
            push_step(5'(i), 24'(i * 'h010101), 24'(i * 'h010101), 24'hFFFFFF,
                      24'(i * 'h010101), 1'b0, (i == 31));
        end
        run(0, 40, 97);

        // num_steps = 0 is ignored.
        num_steps = '0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_val("zero_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        check_val("zero_busy2", 32'(busy), 32'd0);

        // Failing step 0, then table write while busy and abort (with start) during HOLD.
        push_step(0, 24'h000000, 24'h000000, 24'hFFFFFF, 24'hFFFFFF, 1'b0, 1'b0);
        run(3, 4, 0);
        load_addr = 5'd1; load_stim = 24'hDEAD00; load_exp = 24'hDEAD00; load_mask = 24'hFFFFFF;
        load_we = 1'b1;
        @(posedge clk); #1;
        load_we = 1'b0;
        check_val("abort_pre_rdata", 32'(io_rdata), 32'h010101);
        abort = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        start = 1'b0;
        check_val("abort_busy", 32'(busy), 32'd0);
        check_val("abort_rdata", 32'(io_rdata), 32'd0);
        check_val("abort_count", 32'(mismatch_count), 32'd1);
        check_val("abort_done", 32'(done), 32'd0);
        repeat (2) begin
            @(posedge clk); #1;
            check_val("abort_idle_done", 32'(done), 32'd0);
            check_val("abort_idle_busy", 32'(busy), 32'd0);
        end
        push_step(0, 24'h000000, 24'h000000, 24'hFFFFFF, 24'h000000, 1'b0, 1'b0);
        push_step(1, 24'h010101, 24'h010101, 24'hFFFFFF, 24'h010101, 1'b0, 1'b1);
        run(1, 2, 0);

        // Reset during the CHECK of step 1.
        push_step(0, 24'h000000, 24'h000000, 24'hFFFFFF, 24'hFFFFFF, 1'b0, 1'b0);
        run(2, 2, 0);
        repeat (3) @(posedge clk);
        #1;
        io_wdata = 24'hFFFFFF;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        io_wdata = '0;
        check_val("rstmid_rdata", 32'(io_rdata), 32'd0);
        check_val("rstmid_busy", 32'(busy), 32'd0);
        check_val("rstmid_step", 32'(step_idx), 32'd0);
        check_val("rstmid_mismatch", 32'(mismatch), 32'd0);
        check_val("rstmid_count", 32'(mismatch_count), 32'd0);
        check_val("rstmid_ffv", 32'(first_fail_valid), 32'd0);
        push_step(0, 24'h000000, 24'h000000, 24'hFFFFFF, 24'h000000, 1'b0, 1'b0);
        push_step(1, 24'h010101, 24'h010101, 24'hFFFFFF, 24'h010101, 1'b0, 1'b1);
        run(1, 2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
